// File: rtl/pong_pkg.sv
// Shared encodings and legal parameter ranges for the pong match sequencer.
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_COUNTDOWN = 3'd1,
        ST_PLAY      = 3'd2,
        ST_POINT     = 3'd3,
        ST_SET_END   = 3'd4,
        ST_PAUSE     = 3'd5,
        ST_OVER      = 3'd6
    } state_t;

    localparam logic SERVE_LEFT  = 1'b0;
    localparam logic SERVE_RIGHT = 1'b1;

    localparam int WIN_POINTS_MIN  = 1;
    localparam int WIN_POINTS_MAX  = 15;
    localparam int SETS_MIN        = 1;
    localparam int SETS_MAX        = 3;
    localparam int COUNT_START_MIN = 1;
    localparam int COUNT_START_MAX = 3;
    localparam int FRAMES_MIN      = 1;
    localparam int FRAMES_MAX      = 255;

    function automatic int clamp(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

endpackage

// File: rtl/pong_frame_timer.sv
// Saturating 8-bit frame counter shared by every timed state of the match sequencer.
module pong_frame_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       clr,
    input  logic       hold,
    input  logic [7:0] term,
    output logic       at_term,
    output logic       past_term
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = 8'd0;
        end else if (tick && !hold && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_term   = (cnt_q == term);
    assign past_term = (cnt_q >= term);

endmodule

// File: rtl/pong_match_sched.sv
// Points/sets match sequencer: serve countdown, post-point hold, pause and game-over hold,
// driving the animator freeze and exposing scores/state to the text generator.
module pong_match_sched
    import pong_pkg::*;
#(
    parameter int WIN_POINTS   = 7,
    parameter int SETS_TO_WIN  = 2,
    parameter int COUNT_START  = 3,
    parameter int COUNT_FRAMES = 60,
    parameter int HOLD_FRAMES  = 30,
    parameter int OVER_FRAMES  = 120
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       any_key,
    input  logic       pause_key,
    input  logic       left_miss,
    input  logic       right_miss,
    output logic       gra_still,
    output logic       serve_dir,
    output logic [3:0] l_points,
    output logic [3:0] r_points,
    output logic [1:0] l_sets,
    output logic [1:0] r_sets,
    output logic [1:0] countdown,
    output logic [2:0] state_code,
    output logic       winner,
    output logic       match_over
);

    localparam logic [3:0] WIN_PTS   = 4'(clamp(WIN_POINTS, WIN_POINTS_MIN, WIN_POINTS_MAX));
    localparam logic [1:0] SETS_WIN  = 2'(clamp(SETS_TO_WIN, SETS_MIN, SETS_MAX));
    localparam logic [1:0] CD_START  = 2'(clamp(COUNT_START, COUNT_START_MIN, COUNT_START_MAX));
    localparam logic [7:0] CD_TERM   = 8'(clamp(COUNT_FRAMES, FRAMES_MIN, FRAMES_MAX) - 1);
    localparam logic [7:0] HOLD_TERM = 8'(clamp(HOLD_FRAMES, FRAMES_MIN, FRAMES_MAX) - 1);
    localparam logic [7:0] OVER_TERM = 8'(clamp(OVER_FRAMES, FRAMES_MIN, FRAMES_MAX));

    state_t     state_q, state_d, ret_q, ret_d;
    logic [3:0] l_pts_q, l_pts_d, r_pts_q, r_pts_d;
    logic [1:0] l_sets_q, l_sets_d, r_sets_q, r_sets_d;
    logic [1:0] countdown_q, countdown_d;
    logic       winner_q, winner_d, serve_q, serve_d;
    logic       gra_still_q, gra_still_d, match_over_q, match_over_d;
    logic       fcnt_clr, fcnt_hold, at_term, past_term;
    logic [7:0] term;
    logic [3:0] l_pts_inc, r_pts_inc;

    assign l_pts_inc = l_pts_q + 4'd1;
    assign r_pts_inc = r_pts_q + 4'd1;

    always_comb begin
        case (state_q)
            ST_COUNTDOWN:        term = CD_TERM;
            ST_POINT, ST_SET_END: term = HOLD_TERM;
            ST_OVER:             term = OVER_TERM;
            default:             term = 8'd0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        ret_d       = ret_q;
        l_pts_d     = l_pts_q;
        r_pts_d     = r_pts_q;
        l_sets_d    = l_sets_q;
        r_sets_d    = r_sets_q;
        countdown_d = countdown_q;
        winner_d    = winner_q;
        serve_d     = serve_q;
        fcnt_clr    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (any_key) begin
                    state_d     = ST_COUNTDOWN;
                    countdown_d = CD_START;
                end
            end
            ST_COUNTDOWN: begin
                if (pause_key) begin
                    state_d = ST_PAUSE;
                    ret_d   = ST_COUNTDOWN;
                end else if (frame_tick && at_term) begin
                    fcnt_clr = 1'b1;
                    if (countdown_q == 2'd1) begin
                        state_d     = ST_PLAY;
                        countdown_d = 2'd0;
                    end else begin
                        countdown_d = countdown_q - 2'd1;
                    end
                end
            end
            ST_PLAY: begin
                // left_miss outranks right_miss, and any miss outranks pause
                if (left_miss) begin
                    r_pts_d  = (r_pts_q < WIN_PTS) ? r_pts_inc : r_pts_q;
                    winner_d = 1'b0;
                    serve_d  = SERVE_LEFT;
                    if (r_pts_inc == WIN_PTS) begin
                        state_d  = ST_SET_END;
                        r_sets_d = (r_sets_q < SETS_WIN) ? r_sets_q + 2'd1 : r_sets_q;
                    end else begin
                        state_d = ST_POINT;
                    end
                end else if (right_miss) begin
                    l_pts_d  = (l_pts_q < WIN_PTS) ? l_pts_inc : l_pts_q;
                    winner_d = 1'b1;
                    serve_d  = SERVE_RIGHT;
                    if (l_pts_inc == WIN_PTS) begin
                        state_d  = ST_SET_END;
                        l_sets_d = (l_sets_q < SETS_WIN) ? l_sets_q + 2'd1 : l_sets_q;
                    end else begin
                        state_d = ST_POINT;
                    end
                end else if (pause_key) begin
                    state_d = ST_PAUSE;
                    ret_d   = ST_PLAY;
                end
            end
            ST_POINT: begin
                if (frame_tick && at_term) begin
                    state_d     = ST_COUNTDOWN;
                    countdown_d = CD_START;
                end
            end
            ST_SET_END: begin
                if (frame_tick && at_term) begin
                    l_pts_d = 4'd0;
                    r_pts_d = 4'd0;
                    if ((winner_q ? l_sets_q : r_sets_q) == SETS_WIN) begin
                        state_d = ST_OVER;
                    end else begin
                        state_d     = ST_COUNTDOWN;
                        countdown_d = CD_START;
                    end
                end
            end
            ST_PAUSE: begin
                if (pause_key) begin
                    state_d = ret_q;
                end
            end
            ST_OVER: begin
                if (past_term && !any_key) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_IDLE) begin
            l_pts_d     = 4'd0;
            r_pts_d     = 4'd0;
            l_sets_d    = 2'd0;
            r_sets_d    = 2'd0;
            countdown_d = 2'd0;
            winner_d    = 1'b0;
            serve_d     = SERVE_LEFT;
        end

        // Pause entry/exit keeps the frame count so the interrupted state resumes mid-interval
        if ((state_d != state_q) && (state_d != ST_PAUSE) && (state_q != ST_PAUSE)) begin
            fcnt_clr = 1'b1;
        end

        gra_still_d  = (state_d != ST_PLAY);
        match_over_d = (state_d == ST_OVER);
    end

    assign fcnt_hold = (state_q == ST_PAUSE) || (state_d == ST_PAUSE);

    pong_frame_timer u_timer (
        .clk       (clk),
        .reset     (reset),
        .tick      (frame_tick),
        .clr       (fcnt_clr),
        .hold      (fcnt_hold),
        .term      (term),
        .at_term   (at_term),
        .past_term (past_term)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            ret_q        <= ST_IDLE;
            l_pts_q      <= 4'd0;
            r_pts_q      <= 4'd0;
            l_sets_q     <= 2'd0;
            r_sets_q     <= 2'd0;
            countdown_q  <= 2'd0;
            winner_q     <= 1'b0;
            serve_q      <= SERVE_LEFT;
            gra_still_q  <= 1'b1;
            match_over_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ret_q        <= ret_d;
            l_pts_q      <= l_pts_d;
            r_pts_q      <= r_pts_d;
            l_sets_q     <= l_sets_d;
            r_sets_q     <= r_sets_d;
            countdown_q  <= countdown_d;
            winner_q     <= winner_d;
            serve_q      <= serve_d;
            gra_still_q  <= gra_still_d;
            match_over_q <= match_over_d;
        end
    end

    assign gra_still  = gra_still_q;
    assign serve_dir  = serve_q;
    assign l_points   = l_pts_q;
    assign r_points   = r_pts_q;
    assign l_sets     = l_sets_q;
    assign r_sets     = r_sets_q;
    assign countdown  = countdown_q;
    assign state_code = state_q;
    assign winner     = winner_q;
    assign match_over = match_over_q;

endmodule

// File: tb/tb_pong_match_sched.sv
// Directed match walk-through followed by random play, checked against a frame-counting match model.
module tb_pong_match_sched;

    localparam int CF = 2;
    localparam int HF = 2;
    localparam int OF = 4;
    localparam int WP = 3;
    localparam int SW = 2;
    localparam int CS = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       frame_tick = 1'b0, any_key = 1'b0, pause_key = 1'b0;
    logic       left_miss = 1'b0, right_miss = 1'b0;
    logic       gra_still, serve_dir, winner, match_over;
    logic [3:0] l_points, r_points;
    logic [1:0] l_sets, r_sets, countdown;
    logic [2:0] state_code;

    int total = 0;
    int bad   = 0;

    // model: st uses 0 idle,1 countdown,2 play,3 point,4 set end,5 pause,6 over
    int m_st, m_ret, m_fc, m_cd, m_lp, m_rp, m_ls, m_rs, m_win, m_sdir;

    pong_match_sched #(
        .WIN_POINTS(WP), .SETS_TO_WIN(SW), .COUNT_START(CS),
        .COUNT_FRAMES(CF), .HOLD_FRAMES(HF), .OVER_FRAMES(OF)
    ) dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .any_key(any_key),
        .pause_key(pause_key), .left_miss(left_miss), .right_miss(right_miss),
        .gra_still(gra_still), .serve_dir(serve_dir), .l_points(l_points),
        .r_points(r_points), .l_sets(l_sets), .r_sets(r_sets), .countdown(countdown),
        .state_code(state_code), .winner(winner), .match_over(match_over)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_st = 0; m_ret = 0; m_fc = 0; m_cd = 0; m_lp = 0; m_rp = 0;
        m_ls = 0; m_rs = 0; m_win = 0; m_sdir = 0;
    endtask

    task automatic model_step(input bit tk, input bit key, input bit pk, input bit lm, input bit rm);
        case (m_st)
            0: if (key) begin m_st = 1; m_cd = CS; m_fc = 0; end
            1: begin
                if (pk) begin
                    m_ret = 1; m_st = 5;
                end else if (tk) begin
                    m_fc++;
                    if (m_fc == CF) begin
                        m_fc = 0; m_cd--;
                        if (m_cd == 0) m_st = 2;
                    end
                end
            end
            2: begin
                if (lm) begin
                    m_rp++; m_win = 0; m_sdir = 0; m_fc = 0;
                    if (m_rp == WP) begin m_rs++; m_st = 4; end else m_st = 3;
                end else if (rm) begin
                    m_lp++; m_win = 1; m_sdir = 1; m_fc = 0;
                    if (m_lp == WP) begin m_ls++; m_st = 4; end else m_st = 3;
                end else if (pk) begin
                    m_ret = 2; m_st = 5;
                end
            end
            3: if (tk) begin
                m_fc++;
                if (m_fc == HF) begin m_st = 1; m_cd = CS; m_fc = 0; end
            end
            4: if (tk) begin
                m_fc++;
                if (m_fc == HF) begin
                    m_lp = 0; m_rp = 0; m_fc = 0;
                    if ((m_win == 1 ? m_ls : m_rs) == SW) m_st = 6;
                    else begin m_st = 1; m_cd = CS; end
                end
            end
            5: if (pk) m_st = m_ret;
            6: begin
                if (m_fc >= OF && !key) model_reset();
                else if (tk && m_fc < 255) m_fc++;
            end
            default: model_reset();
        endcase
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        logic [20:0] obs, exp, mask;
        obs = {state_code, gra_still, serve_dir, l_points, r_points, l_sets, r_sets,
               countdown, winner, match_over};
        exp = {3'(m_st), (m_st != 2), 1'(m_sdir), 4'(m_lp), 4'(m_rp), 2'(m_ls), 2'(m_rs),
               2'((m_st == 1) ? m_cd : 0), 1'(m_win), (m_st == 6)};
        // the digit shown while paused is not part of the contract being modelled
        mask = (m_st == 5) ? ~21'h0000C : ~21'h0;
        check(tag, 32'(obs & mask), 32'(exp & mask));
    endtask

    task automatic step(input bit tk, input bit key, input bit pk, input bit lm, input bit rm);
        frame_tick = tk; any_key = key; pause_key = pk; left_miss = lm; right_miss = rm;
        @(posedge clk);
        model_step(tk, key, pk, lm, rm);
        #1;
        frame_tick = 0; any_key = 0; pause_key = 0; left_miss = 0; right_miss = 0;
        check_model("snapshot");
        $display("t=%0t tk=%0d key=%0d pk=%0d lm=%0d rm=%0d -> st=%0d cd=%0d pts=%0d:%0d sets=%0d:%0d",
                 $time, tk, key, pk, lm, rm, state_code, countdown, l_points, r_points, l_sets, r_sets);
    endtask

    task automatic ticks(input int n);
        repeat (n) step(1, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check_model("reset_async");
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_model("reset_hold");
    endtask

    initial begin
        int cd_seq[6];
        cd_seq = '{3, 2, 2, 1, 1, 0};
        model_reset();

        // reset values and countdown into play
        do_reset();
        check("rst_state", state_code, 0);
        check("rst_still", gra_still, 1);
        step(0, 1, 0, 0, 0);
        check("cd_start", countdown, 3);
        check("cd_state", state_code, 1);
        for (int i = 0; i < 6; i++) begin
            step(1, 0, 0, 0, 0);
            check("cd_seq", countdown, cd_seq[i]);
        end
        check("play_state", state_code, 2);
        check("play_still", gra_still, 0);

        // right miss scores for the left player
        step(0, 0, 0, 0, 1);
        check("rmiss_lpts", l_points, 1);
        check("rmiss_win", winner, 1);
        check("rmiss_serve", serve_dir, 1);
        check("rmiss_state", state_code, 3);
        ticks(1);
        check("point_hold", state_code, 3);
        ticks(1);
        check("point_to_cd", state_code, 1);

        // pause at digit 2 with one frame already counted
        ticks(3);
        check("pre_pause_cd", countdown, 2);
        step(0, 0, 1, 0, 0);
        check("pause_state", state_code, 5);
        ticks(10);
        step(0, 0, 0, 1, 0);
        check("pause_state2", state_code, 5);
        check("pause_nomiss", r_points, 0);
        check("pause_still", gra_still, 1);
        step(0, 0, 1, 0, 0);
        check("resume_state", state_code, 1);
        check("resume_cd", countdown, 2);
        ticks(1);
        check("resume_fcnt", countdown, 1);
        ticks(2);
        check("resume_play", state_code, 2);

        // simultaneous misses: only the left miss counts
        step(0, 0, 0, 1, 1);
        check("both_rpts", r_points, 1);
        check("both_lpts", l_points, 1);
        check("both_serve", serve_dir, 0);
        ticks(8);

        // left player takes two sets
        step(0, 0, 0, 0, 1);
        ticks(8);
        step(0, 0, 0, 0, 1);
        check("set1_state", state_code, 4);
        check("set1_lsets", l_sets, 1);
        check("set1_lpts", l_points, 3);
        ticks(1);
        check("set1_hold", l_points, 3);
        ticks(1);
        check("set1_clear", l_points, 0);
        check("set1_cd", state_code, 1);
        ticks(6);
        for (int i = 0; i < 2; i++) begin
            step(0, 0, 0, 0, 1);
            ticks(8);
        end
        step(0, 0, 0, 0, 1);
        check("set2_lsets", l_sets, 2);
        ticks(2);
        check("over_state", state_code, 6);
        check("over_flag", match_over, 1);
        check("over_win", winner, 1);
        repeat (6) step(1, 1, 0, 0, 0);
        check("over_keyhold", state_code, 6);
        step(0, 0, 0, 0, 0);
        check("over_exit", state_code, 0);
        check("over_lsets", l_sets, 0);
        check("over_flag0", match_over, 0);

        // reset while paused
        step(0, 1, 0, 0, 0);
        ticks(6);
        step(0, 0, 0, 0, 1);
        ticks(2);
        step(0, 0, 1, 0, 0);
        check("pre_rst_pause", state_code, 5);
        check("pre_rst_lpts", l_points, 1);
        do_reset();
        check("prst_state", state_code, 0);
        check("prst_lpts", l_points, 0);
        check("prst_over", match_over, 0);

        // random play against the model
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                     $urandom_range(0, 11) == 0, $urandom_range(0, 7) == 0,
                     $urandom_range(0, 7) == 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
